// File: rtl/control_unit_if.sv
// Data-path control interface between the K&S sequencer (master) and the data path (slave).
// The data path presents the IR decode and registered flags; the sequencer returns the control strobes.
interface control_unit_if;
    logic [4:0] decoded_instruction;
    logic       zero_op;
    logic       neg_op;
    logic       unsigned_overflow;
    logic       signed_overflow;
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
        output write_reg_enable, flags_reg_enable
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
        input  write_reg_enable, flags_reg_enable
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer for the K&S core: walks FETCH/DECODE/execute states,
// drives the data-path strobes combinationally and counts retired instructions.
package k_and_s_pkg;
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_LOAD_1  = 3'd2,
        S_LOAD_2  = 3'd3,
        S_STORE_1 = 3'd4,
        S_EXEC    = 3'd5,
        S_BRANCH  = 3'd6,
        S_HALT    = 3'd7
    } cu_state_t;
endpackage

module control_unit
    import k_and_s_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    control_unit_if.master   cu,
    output logic             ram_write_enable,
    output logic             halt,
    output logic [CNT_W-1:0] retired_count,
    output cu_state_t        state_dbg
);
    cu_state_t               state;
    cu_state_t               next_state;
    decoded_instruction_type instr;
    logic                    cond;
    logic                    retire;
    logic                    unused_flag;

    assign instr       = decoded_instruction_type'(cu.decoded_instruction);
    assign unused_flag = cu.unsigned_overflow;
    assign state_dbg   = state;

    always_comb begin
        cond = 1'b0;
        case (instr)
            I_BRANCH: cond = 1'b1;
            I_BZERO:  cond = cu.zero_op;
            I_BNZERO: cond = !cu.zero_op;
            I_BNEG:   cond = cu.neg_op;
            I_BNNEG:  cond = !cu.neg_op;
            I_BOV:    cond = cu.signed_overflow;
            I_BNOV:   cond = !cu.signed_overflow;
            default:  cond = 1'b0;
        endcase
    end

    // Unknown encodings fall back to FETCH and retire like a NOP.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (instr)
                    I_LOAD:  next_state = S_LOAD_1;
                    I_STORE: next_state = S_STORE_1;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
                             next_state = S_EXEC;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                             next_state = S_BRANCH;
                    I_HALT: begin
                        next_state = S_HALT;
                        retire     = 1'b1;
                    end
                    default: begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                endcase
            end
            S_LOAD_1: next_state = S_LOAD_2;
            S_LOAD_2, S_STORE_1, S_EXEC, S_BRANCH: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    // Strobes are forced low during reset so no write can slip through the reset cycle.
    always_comb begin
        cu.branch           = 1'b0;
        cu.pc_enable        = 1'b0;
        cu.ir_enable        = 1'b0;
        cu.addr_sel         = 1'b0;
        cu.c_sel            = 1'b0;
        cu.operation        = 2'b00;
        cu.write_reg_enable = 1'b0;
        cu.flags_reg_enable = 1'b0;
        ram_write_enable    = 1'b0;
        halt                = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH:  cu.ir_enable = 1'b1;
                S_DECODE: cu.pc_enable = 1'b1;
                S_LOAD_1: cu.addr_sel  = 1'b1;
                S_LOAD_2: begin
                    cu.addr_sel         = 1'b1;
                    cu.c_sel            = 1'b1;
                    cu.write_reg_enable = 1'b1;
                end
                S_STORE_1: begin
                    cu.addr_sel      = 1'b1;
                    ram_write_enable = 1'b1;
                end
                S_EXEC: begin
                    cu.write_reg_enable = 1'b1;
                    case (instr)
                        I_ADD: begin cu.operation = 2'b00; cu.flags_reg_enable = 1'b1; end
                        I_SUB: begin cu.operation = 2'b01; cu.flags_reg_enable = 1'b1; end
                        I_AND: begin cu.operation = 2'b10; cu.flags_reg_enable = 1'b1; end
                        I_OR:  begin cu.operation = 2'b11; cu.flags_reg_enable = 1'b1; end
                        I_MOVE: cu.operation = 2'b11;
                        default: cu.operation = 2'b00;
                    endcase
                end
                S_BRANCH: begin
                    cu.branch    = cond;
                    cu.pc_enable = cond;
                end
                S_HALT:  halt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            retired_count <= '0;
        end else begin
            state <= next_state;
            if (retire)
                retired_count <= retired_count + 1'b1;
        end
    end

    a_branch_pc: assert property (@(posedge clk) cu.branch |-> cu.pc_enable);
    a_wr_excl:   assert property (@(posedge clk) !(ram_write_enable && cu.write_reg_enable));
    a_ir_fetch:  assert property (@(posedge clk) cu.ir_enable |-> (state == S_FETCH));
endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: reset, NOP stream, ALU/MOVE, LOAD/STORE,
// conditional branches, illegal encoding, HALT and reset recovery.
module tb_control_unit;
    import k_and_s_pkg::*;

    logic        clk;
    logic        rst;
    logic        ram_write_enable;
    logic        halt;
    logic [15:0] retired_count;
    cu_state_t   state_dbg;
    int          n_vec;
    int          n_err;
    logic [15:0] exp_cnt;

    control_unit_if cu_if ();

    control_unit #(.CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .cu               (cu_if.master),
        .ram_write_enable (ram_write_enable),
        .halt             (halt),
        .retired_count    (retired_count),
        .state_dbg        (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        decoded_instruction_type instr;
        logic [1:0]              op;
        logic                    fre;
    } alu_vec_t;

    typedef struct {
        decoded_instruction_type instr;
        logic                    z;
        logic                    n;
        logic                    v;
        logic                    taken;
    } br_vec_t;

    alu_vec_t alu_tab[5];
    br_vec_t  br_tab[9];

    initial begin
        n_vec = 0;
        n_err = 0;
        alu_tab[0] = '{I_ADD,  2'b00, 1'b1};
        alu_tab[1] = '{I_SUB,  2'b01, 1'b1};
        alu_tab[2] = '{I_AND,  2'b10, 1'b1};
        alu_tab[3] = '{I_OR,   2'b11, 1'b1};
        alu_tab[4] = '{I_MOVE, 2'b11, 1'b0};
        br_tab[0]  = '{I_BZERO,  1'b1, 1'b0, 1'b0, 1'b1};
        br_tab[1]  = '{I_BZERO,  1'b0, 1'b0, 1'b0, 1'b0};
        br_tab[2]  = '{I_BNOV,   1'b0, 1'b0, 1'b1, 1'b0};
        br_tab[3]  = '{I_BNOV,   1'b0, 1'b0, 1'b0, 1'b1};
        br_tab[4]  = '{I_BRANCH, 1'b0, 1'b0, 1'b0, 1'b1};
        br_tab[5]  = '{I_BNZERO, 1'b0, 1'b0, 1'b0, 1'b1};
        br_tab[6]  = '{I_BNEG,   1'b0, 1'b1, 1'b0, 1'b1};
        br_tab[7]  = '{I_BNNEG,  1'b0, 1'b1, 1'b0, 1'b0};
        br_tab[8]  = '{I_BOV,    1'b0, 1'b0, 1'b1, 1'b1};

        rst                          = 1'b1;
        cu_if.decoded_instruction    = I_NOP;
        cu_if.zero_op                = 1'b0;
        cu_if.neg_op                 = 1'b0;
        cu_if.unsigned_overflow      = 1'b0;
        cu_if.signed_overflow        = 1'b0;

        tick();
        tick();
        check("rst_ir_low", 32'(cu_if.ir_enable), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state_dbg), 32'(S_FETCH));
        check("rst_count", 32'(retired_count), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_pc_en", 32'(cu_if.pc_enable), 32'd0);

        // NOP stream: ir_enable alternates, one retirement per two cycles.
        for (int i = 0; i < 10; i++) begin
            check($sformatf("nop_ir[%0d]", i), 32'(cu_if.ir_enable), 32'((i % 2) == 0));
            tick();
        end
        check("nop_count", 32'(retired_count), 32'd5);
        exp_cnt = 16'd5;

        for (int i = 0; i < 5; i++) begin
            cu_if.decoded_instruction = alu_tab[i].instr;
            tick();
            check("alu_dec_pc", 32'(cu_if.pc_enable), 32'd1);
            check("alu_dec_br", 32'(cu_if.branch), 32'd0);
            tick();
            check($sformatf("alu_op[%0d]", i), 32'(cu_if.operation), 32'(alu_tab[i].op));
            check($sformatf("alu_fre[%0d]", i), 32'(cu_if.flags_reg_enable), 32'(alu_tab[i].fre));
            check("alu_wre", 32'(cu_if.write_reg_enable), 32'd1);
            check("alu_csel", 32'(cu_if.c_sel), 32'd0);
            tick();
            exp_cnt++;
            check("alu_fetch", 32'(cu_if.ir_enable), 32'd1);
            check("alu_count", 32'(retired_count), 32'(exp_cnt));
        end

        cu_if.decoded_instruction = I_LOAD;
        tick();
        tick();
        check("ld1_addr", 32'(cu_if.addr_sel), 32'd1);
        check("ld1_csel", 32'(cu_if.c_sel), 32'd0);
        check("ld1_wre", 32'(cu_if.write_reg_enable), 32'd0);
        check("ld1_count", 32'(retired_count), 32'(exp_cnt));
        tick();
        check("ld2_addr", 32'(cu_if.addr_sel), 32'd1);
        check("ld2_csel", 32'(cu_if.c_sel), 32'd1);
        check("ld2_wre", 32'(cu_if.write_reg_enable), 32'd1);
        tick();
        exp_cnt++;
        check("ld_fetch", 32'(cu_if.ir_enable), 32'd1);
        check("ld_count", 32'(retired_count), 32'(exp_cnt));

        cu_if.decoded_instruction = I_STORE;
        tick();
        check("st_dec_rwe", 32'(ram_write_enable), 32'd0);
        tick();
        check("st_addr", 32'(cu_if.addr_sel), 32'd1);
        check("st_rwe", 32'(ram_write_enable), 32'd1);
        check("st_wre", 32'(cu_if.write_reg_enable), 32'd0);
        tick();
        exp_cnt++;
        check("st_fetch", 32'(cu_if.ir_enable), 32'd1);
        check("st_rwe_off", 32'(ram_write_enable), 32'd0);
        check("st_count", 32'(retired_count), 32'(exp_cnt));

        for (int i = 0; i < 9; i++) begin
            cu_if.decoded_instruction = br_tab[i].instr;
            cu_if.zero_op             = br_tab[i].z;
            cu_if.neg_op              = br_tab[i].n;
            cu_if.signed_overflow     = br_tab[i].v;
            cu_if.unsigned_overflow   = ~br_tab[i].v;
            tick();
            tick();
            check($sformatf("br_branch[%0d]", i), 32'(cu_if.branch), 32'(br_tab[i].taken));
            check($sformatf("br_pc_en[%0d]", i), 32'(cu_if.pc_enable), 32'(br_tab[i].taken));
            tick();
            exp_cnt++;
            check($sformatf("br_count[%0d]", i), 32'(retired_count), 32'(exp_cnt));
        end
        cu_if.zero_op           = 1'b0;
        cu_if.neg_op            = 1'b0;
        cu_if.signed_overflow   = 1'b0;
        cu_if.unsigned_overflow = 1'b0;

        // Unassigned encoding behaves like a NOP.
        cu_if.decoded_instruction = 5'd25;
        tick();
        tick();
        exp_cnt++;
        check("ill_state", 32'(state_dbg), 32'(S_FETCH));
        check("ill_count", 32'(retired_count), 32'(exp_cnt));

        cu_if.decoded_instruction = I_HALT;
        tick();
        tick();
        exp_cnt++;
        check("halt_on", 32'(halt), 32'd1);
        check("halt_count", 32'(retired_count), 32'(exp_cnt));
        cu_if.decoded_instruction = I_NOP;
        for (int i = 0; i < 5; i++) tick();
        check("halt_hold", 32'(halt), 32'd1);
        check("halt_frozen", 32'(retired_count), 32'(exp_cnt));
        check("halt_ir", 32'(cu_if.ir_enable), 32'd0);

        rst = 1'b1;
        #1;
        check("halt_rst_gate", 32'(halt), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rec_ir", 32'(cu_if.ir_enable), 32'd1);
        check("rec_halt", 32'(halt), 32'd0);
        check("rec_count", 32'(retired_count), 32'd0);

        // Reset asserted in EXEC must suppress the register write.
        cu_if.decoded_instruction = I_ADD;
        tick();
        tick();
        check("mid_exec_wre", 32'(cu_if.write_reg_enable), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_wre", 32'(cu_if.write_reg_enable), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_state", 32'(state_dbg), 32'(S_FETCH));
        check("mid_count", 32'(retired_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
